addr_seq_gen: RTL and testbench



---
 rtl/addr_seq_pkg.sv | 11 +
 rtl/addr_step_calc.sv | 87 ++++++++
 rtl/addr_seq_gen.sv | 101 ++++++++++
 tb/tb_addr_seq_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types for the windowed address sequencer: traversal-mode encodings.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

endpackage : addr_seq_pkg

// File: rtl/addr_step_calc.sv
// Combinational step logic: next address, carry event, ping-pong turnaround and
// one-shot end for a given position, window, stride, direction and mode.
module addr_step_calc
    import addr_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic [ADDR_W-1:0] step,
    input  logic              dir,
    input  mode_e             mode,
    output logic [ADDR_W-1:0] next_addr,
    output logic              carry_evt,
    output logic              turnaround,
    output logic              os_end
);

    logic [ADDR_W:0] addr_x, lo_x, hi_x, step_x;
    logic [ADDR_W:0] sum_x, diff_x, lo_p_step_x, back_up_x, back_dn_x;
    logic            over, under;

    always_comb begin
        addr_x      = {1'b0, address};
        lo_x        = {1'b0, lo};
        hi_x        = {1'b0, hi};
        step_x      = (step == '0) ? {{ADDR_W{1'b0}}, 1'b1} : {1'b0, step};
        sum_x       = addr_x + step_x;
        diff_x      = addr_x - step_x;
        lo_p_step_x = lo_x + step_x;
        // Underflow is judged as address < lo+step so the borrow never wraps.
        over        = sum_x > hi_x;
        under       = addr_x < lo_p_step_x;
        back_up_x   = (hi_x < lo_p_step_x) ? lo_x : hi_x - step_x;
        back_dn_x   = (lo_p_step_x > hi_x) ? hi_x : lo_p_step_x;

        next_addr  = address;
        carry_evt  = 1'b0;
        turnaround = 1'b0;
        os_end     = 1'b0;

        case (mode)
            MODE_PINGPONG: begin
                if (dir) begin
                    if (address == hi) begin
                        turnaround = 1'b1;
                        carry_evt  = 1'b1;
                        next_addr  = back_up_x[ADDR_W-1:0];
                    end else if (over) begin
                        next_addr = hi;
                    end else begin
                        next_addr = sum_x[ADDR_W-1:0];
                    end
                end else begin
                    if (address == lo) begin
                        turnaround = 1'b1;
                        carry_evt  = 1'b1;
                        next_addr  = back_dn_x[ADDR_W-1:0];
                    end else if (under) begin
                        next_addr = lo;
                    end else begin
                        next_addr = diff_x[ADDR_W-1:0];
                    end
                end
            end
            MODE_ONESHOT: begin
                if (dir ? over : under) begin
                    os_end    = 1'b1;
                    carry_evt = 1'b1;
                end else begin
                    next_addr = dir ? sum_x[ADDR_W-1:0] : diff_x[ADDR_W-1:0];
                end
            end
            default: begin
                if (dir) begin
                    carry_evt = over;
                    next_addr = over ? lo : sum_x[ADDR_W-1:0];
                end else begin
                    carry_evt = under;
                    next_addr = under ? hi : diff_x[ADDR_W-1:0];
                end
            end
        endcase
    end

endmodule : addr_step_calc

// File: rtl/addr_seq_gen.sv
// Windowed address sequencer: registers, reset/preset/enable priority,
// sticky one-shot done and window configuration error flag.
module addr_seq_gen
    import addr_seq_pkg::*;
#(
    parameter int unsigned           ADDR_W     = 4,
    parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              preset,
    input  logic              en,
    input  logic              up_down,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] address,
    output logic              carry,
    output logic              done,
    output logic              dir,
    output logic              cfg_err
);

    logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
    logic              carry_q, carry_d;
    logic              done_q, done_d;
    logic              dir_q, dir_d;
    logic              cfg_err_q, cfg_err_d;
    logic              dir_eff, bad_cfg, out_win;
    logic              carry_evt, turnaround, os_end;
    mode_e             mode_m;

    always_comb begin
        mode_m  = mode_e'(mode);
        // Ping-pong keeps its own direction; other modes track up_down directly.
        dir_eff = (mode_m == MODE_PINGPONG) ? dir_q : up_down;
        bad_cfg = lo > hi;
        out_win = (addr_q < lo) || (addr_q > hi);
    end

    addr_step_calc #(.ADDR_W(ADDR_W)) u_step (
        .address    (addr_q),
        .lo         (lo),
        .hi         (hi),
        .step       (step),
        .dir        (dir_eff),
        .mode       (mode_m),
        .next_addr  (next_addr),
        .carry_evt  (carry_evt),
        .turnaround (turnaround),
        .os_end     (os_end)
    );

    always_comb begin
        addr_d    = addr_q;
        dir_d     = dir_q;
        done_d    = done_q;
        carry_d   = 1'b0;
        cfg_err_d = bad_cfg;

        if (preset) begin
            addr_d = up_down ? lo : hi;
            dir_d  = up_down;
            done_d = 1'b0;
        end else if (en && !bad_cfg && !(mode_m == MODE_ONESHOT && done_q)) begin
            dir_d = dir_eff;
            if (out_win) begin
                addr_d = dir_eff ? lo : hi;
            end else begin
                addr_d  = next_addr;
                carry_d = carry_evt;
                if (turnaround) dir_d = ~dir_eff;
                if (os_end) done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= RESET_ADDR;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            dir_q     <= 1'b1;
            cfg_err_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            dir_q     <= dir_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign address = addr_q;
    assign carry   = carry_q;
    assign done    = done_q;
    assign dir     = dir_q;
    assign cfg_err = cfg_err_q;

endmodule : addr_seq_gen

// File: tb/tb_addr_seq_gen.sv
// Scoreboard bench for addr_seq_gen: driver queues hand-computed expectations,
// monitor compares them against the registered outputs after each edge.
module tb_addr_seq_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1, preset = 1'b0, en = 1'b0, up_down = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] lo = '0, hi = '0, step = '0;
    logic [3:0] address;
    logic       carry, done, dir, cfg_err;

    typedef struct {
        logic [3:0] addr;
        logic       carry;
        logic       done;
        logic       dir;
        logic       cerr;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    localparam logic [1:0] WR = 2'd0, PP = 2'd1, OS = 2'd2, RS = 2'd3;

    addr_seq_gen #(.ADDR_W(4), .RESET_ADDR(4'd0)) dut (
        .clk     (clk),
        .reset   (reset),
        .preset  (preset),
        .en      (en),
        .up_down (up_down),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .step    (step),
        .address (address),
        .carry   (carry),
        .done    (done),
        .dir     (dir),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic p, input logic e, input logic ud,
                       input logic [1:0] m, input logic [3:0] l, input logic [3:0] h,
                       input logic [3:0] s, input logic [3:0] ea, input logic ec,
                       input logic ed, input logic edir, input logic ecerr,
                       input string nm);
        exp_t x;
        @(negedge clk);
        reset = r; preset = p; en = e; up_down = ud; mode = m;
        lo = l; hi = h; step = s;
        x.addr = ea; x.carry = ec; x.done = ed; x.dir = edir; x.cerr = ecerr; x.name = nm;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (address !== x.addr || carry !== x.carry || done !== x.done ||
                dir !== x.dir || cfg_err !== x.cerr) begin
                failures++;
                $display("FAIL %s: got addr=%0d carry=%b done=%b dir=%b cfg_err=%b, want addr=%0d carry=%b done=%b dir=%b cfg_err=%b",
                         x.name, address, carry, done, dir, cfg_err,
                         x.addr, x.carry, x.done, x.dir, x.cerr);
            end
        end
    end

    initial begin
        //   r  p  e  ud mode lo   hi    st    addr c  d  dir cerr
        cyc(1, 0, 0, 1, WR, 4'd2, 4'd9, 4'd3, 4'd0, 0, 0, 1, 0, "reset");
        // WRAP up, window [2,9], stride 3
        cyc(0, 1, 0, 1, WR, 4'd2, 4'd9, 4'd3, 4'd2, 0, 0, 1, 0, "wrap_preset");
        cyc(0, 0, 1, 1, WR, 4'd2, 4'd9, 4'd3, 4'd5, 0, 0, 1, 0, "wrap_5");
        cyc(0, 0, 1, 1, WR, 4'd2, 4'd9, 4'd3, 4'd8, 0, 0, 1, 0, "wrap_8");
        cyc(0, 0, 1, 1, WR, 4'd2, 4'd9, 4'd3, 4'd2, 1, 0, 1, 0, "wrap_to_lo");
        cyc(0, 0, 1, 1, WR, 4'd2, 4'd9, 4'd3, 4'd5, 0, 0, 1, 0, "wrap_5b");
        cyc(0, 0, 0, 1, WR, 4'd2, 4'd9, 4'd3, 4'd5, 0, 0, 1, 0, "wrap_hold");
        // PINGPONG [0,15] stride 4
        cyc(0, 1, 0, 1, PP, 4'd0, 4'd15, 4'd4, 4'd0, 0, 0, 1, 0, "pp_preset");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd4, 0, 0, 1, 0, "pp_4");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd8, 0, 0, 1, 0, "pp_8");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd12, 0, 0, 1, 0, "pp_12");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd15, 0, 0, 1, 0, "pp_clamp_hi");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd11, 1, 0, 0, 0, "pp_turn_hi");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd7, 0, 0, 0, 0, "pp_7");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd3, 0, 0, 0, 0, "pp_3");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd0, 0, 0, 0, 0, "pp_clamp_lo");
        cyc(0, 0, 1, 1, PP, 4'd0, 4'd15, 4'd4, 4'd4, 1, 0, 1, 0, "pp_turn_lo");
        // ONESHOT up [0,5] stride 2
        cyc(0, 1, 0, 1, OS, 4'd0, 4'd5, 4'd2, 4'd0, 0, 0, 1, 0, "os_preset");
        cyc(0, 0, 1, 1, OS, 4'd0, 4'd5, 4'd2, 4'd2, 0, 0, 1, 0, "os_2");
        cyc(0, 0, 1, 1, OS, 4'd0, 4'd5, 4'd2, 4'd4, 0, 0, 1, 0, "os_4");
        cyc(0, 0, 1, 1, OS, 4'd0, 4'd5, 4'd2, 4'd4, 1, 1, 1, 0, "os_end");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 1, OS, 4'd0, 4'd5, 4'd2, 4'd4, 0, 1, 1, 0, "os_stuck");
        cyc(0, 1, 0, 1, OS, 4'd0, 4'd5, 4'd2, 4'd0, 0, 0, 1, 0, "os_represet");
        // reset beats preset and en mid-run at address 8
        cyc(0, 1, 0, 1, WR, 4'd0, 4'd15, 4'd4, 4'd0, 0, 0, 1, 0, "rst_preset");
        cyc(0, 0, 1, 1, WR, 4'd0, 4'd15, 4'd4, 4'd4, 0, 0, 1, 0, "rst_4");
        cyc(0, 0, 1, 1, WR, 4'd0, 4'd15, 4'd4, 4'd8, 0, 0, 1, 0, "rst_8");
        cyc(1, 1, 1, 0, WR, 4'd2, 4'd15, 4'd4, 4'd0, 0, 0, 1, 0, "rst_priority");
        // out-of-window reload, then inverted window
        cyc(0, 0, 1, 1, WR, 4'd0, 4'd15, 4'd4, 4'd4, 0, 0, 1, 0, "oow_4");
        cyc(0, 0, 1, 1, WR, 4'd0, 4'd15, 4'd4, 4'd8, 0, 0, 1, 0, "oow_8");
        cyc(0, 0, 1, 1, WR, 4'd0, 4'd15, 4'd4, 4'd12, 0, 0, 1, 0, "oow_12");
        cyc(0, 0, 1, 1, WR, 4'd3, 4'd10, 4'd4, 4'd3, 0, 0, 1, 0, "oow_reload");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 1, WR, 4'd9, 4'd4, 4'd4, 4'd3, 0, 0, 1, 1, "cfgerr_frozen");
        cyc(0, 1, 0, 1, WR, 4'd9, 4'd4, 4'd4, 4'd9, 0, 0, 1, 1, "cfgerr_preset");
        cyc(0, 0, 1, 1, WR, 4'd9, 4'd4, 4'd4, 4'd9, 0, 0, 1, 1, "cfgerr_frozen2");
        // legacy 4-bit down counter, step 0 treated as 1
        cyc(0, 1, 0, 1, WR, 4'd3, 4'd15, 4'd0, 4'd3, 0, 0, 1, 0, "leg_preset3");
        cyc(0, 0, 1, 0, WR, 4'd0, 4'd15, 4'd0, 4'd2, 0, 0, 0, 0, "leg_2");
        cyc(0, 0, 1, 0, WR, 4'd0, 4'd15, 4'd0, 4'd1, 0, 0, 0, 0, "leg_1");
        cyc(0, 0, 1, 0, WR, 4'd0, 4'd15, 4'd0, 4'd0, 0, 0, 0, 0, "leg_0");
        cyc(0, 0, 1, 0, WR, 4'd0, 4'd15, 4'd0, 4'd15, 1, 0, 0, 0, "leg_wrap_15");
        cyc(0, 0, 1, 0, WR, 4'd0, 4'd15, 4'd0, 4'd14, 0, 0, 0, 0, "leg_14");
        // reserved mode behaves as wrap; dir follows up_down
        cyc(0, 0, 1, 1, RS, 4'd0, 4'd15, 4'd0, 4'd15, 0, 0, 1, 0, "rsvd_15");
        cyc(0, 0, 1, 1, RS, 4'd0, 4'd15, 4'd0, 4'd0, 1, 0, 1, 0, "rsvd_wrap_0");
        cyc(0, 0, 0, 1, RS, 4'd0, 4'd15, 4'd0, 4'd0, 0, 0, 1, 0, "rsvd_hold");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_addr_seq_gen
